// File: rtl/cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : cond_flag_unit
// Description : Registers ALU result and NZCV flags, evaluates the ARM
//               condition field and gates the instruction write enables.
// Revision    : 1.0
// ============================================================================
module cond_flag_unit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] alu_result_i,
    input  logic [3:0]   alu_flags_i,
    input  logic [3:0]   cond,
    input  logic [1:0]   flag_w,
    input  logic         cond_latch,
    input  logic         pcs,
    input  logic         pc_next,
    input  logic         reg_w,
    input  logic         mem_w,
    input  logic         no_write,
    output logic [3:0]   flags_q,
    output logic [W-1:0] alu_out_q,
    output logic         cond_ex,
    output logic         undef_cond,
    output logic         pc_write,
    output logic         reg_write,
    output logic         mem_write
);

    localparam logic [3:0] c_cond_nv = 4'b1111;

    logic [3:0]   r_flags;
    logic [W-1:0] r_alu_out;
    logic         r_cond_ex;
    logic         r_undef_cond;
    logic         w_n;
    logic         w_z;
    logic         w_c;
    logic         w_v;
    logic         w_pass;

    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    always_comb begin
        w_pass = 1'b0;
        case (cond)
            4'b0000: w_pass = w_z;
            4'b0001: w_pass = ~w_z;
            4'b0010: w_pass = w_c;
            4'b0011: w_pass = ~w_c;
            4'b0100: w_pass = w_n;
            4'b0101: w_pass = ~w_n;
            4'b0110: w_pass = w_v;
            4'b0111: w_pass = ~w_v;
            4'b1000: w_pass = w_c & ~w_z;
            4'b1001: w_pass = ~w_c | w_z;
            4'b1010: w_pass = (w_n == w_v);
            4'b1011: w_pass = (w_n != w_v);
            4'b1100: w_pass = ~w_z & (w_n == w_v);
            4'b1101: w_pass = w_z | (w_n != w_v);
            4'b1110: w_pass = 1'b1;
            default: w_pass = 1'b0;
        endcase
    end

    // Flag writes are gated by the decision latched for the current instruction,
    // so a same-edge cond_latch cannot affect its own cycle's flag update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flags      <= 4'b0000;
            r_alu_out    <= '0;
            r_cond_ex    <= 1'b1;
            r_undef_cond <= 1'b0;
        end else begin
            r_alu_out <= alu_result_i;
            if (flag_w[1] && r_cond_ex) begin
                r_flags[3:2] <= alu_flags_i[3:2];
            end
            if (flag_w[0] && r_cond_ex) begin
                r_flags[1:0] <= alu_flags_i[1:0];
            end
            if (cond_latch) begin
                r_cond_ex    <= w_pass;
                r_undef_cond <= (cond == c_cond_nv);
            end
        end
    end

    assign flags_q    = r_flags;
    assign alu_out_q  = r_alu_out;
    assign cond_ex    = r_cond_ex;
    assign undef_cond = r_undef_cond;
    assign pc_write   = pc_next | (pcs & r_cond_ex);
    assign reg_write  = reg_w & r_cond_ex & ~no_write;
    assign mem_write  = mem_w & r_cond_ex;

endmodule
`default_nettype wire

// File: tb/tb_cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cond_flag_unit
// Description : Vector table, directed corner sequences and random stimulus
//               against a reference model of cond_flag_unit.
// Revision    : 1.0
// ============================================================================
module tb_cond_flag_unit;

    localparam int c_w = 32;

    logic           clk;
    logic           run;
    logic           reset_n;
    logic [c_w-1:0] alu_result_i;
    logic [3:0]     alu_flags_i;
    logic [3:0]     cond;
    logic [1:0]     flag_w;
    logic           cond_latch;
    logic           pcs;
    logic           pc_next;
    logic           reg_w;
    logic           mem_w;
    logic           no_write;
    logic [3:0]     flags_q;
    logic [c_w-1:0] alu_out_q;
    logic           cond_ex;
    logic           undef_cond;
    logic           pc_write;
    logic           reg_write;
    logic           mem_write;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference state
    logic [3:0]     m_flags;
    logic [c_w-1:0] m_alu;
    logic           m_cond_ex;
    logic           m_undef;

    cond_flag_unit #(.W(c_w)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .alu_result_i (alu_result_i),
        .alu_flags_i  (alu_flags_i),
        .cond         (cond),
        .flag_w       (flag_w),
        .cond_latch   (cond_latch),
        .pcs          (pcs),
        .pc_next      (pc_next),
        .reg_w        (reg_w),
        .mem_w        (mem_w),
        .no_write     (no_write),
        .flags_q      (flags_q),
        .alu_out_q    (alu_out_q),
        .cond_ex      (cond_ex),
        .undef_cond   (undef_cond),
        .pc_write     (pc_write),
        .reg_write    (reg_write),
        .mem_write    (mem_write)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (run) clk = ~clk;
    end

    // Pairs of conditions share a base test; the odd member is its negation.
    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = (n == v) && !z;
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flags   = 4'b0000;
        m_alu     = '0;
        m_cond_ex = 1'b1;
        m_undef   = 1'b0;
    endtask

    // One clock edge; the model advances from the same pre-edge inputs/state.
    task automatic step();
        logic [3:0] nf;
        logic       nce, nu;
        nf  = m_flags;
        nce = m_cond_ex;
        nu  = m_undef;
        if (m_cond_ex && flag_w[1]) nf[3:2] = alu_flags_i[3:2];
        if (m_cond_ex && flag_w[0]) nf[1:0] = alu_flags_i[1:0];
        if (cond_latch) begin
            nce = ref_pass(cond, m_flags);
            nu  = (cond == 4'hF);
        end
        @(posedge clk);
        m_flags   = nf;
        m_cond_ex = nce;
        m_undef   = nu;
        m_alu     = alu_result_i;
        #1;
    endtask

    task automatic idle_inputs();
        alu_result_i = '0; alu_flags_i = 4'b0000; cond = 4'b1110;
        flag_w = 2'b00; cond_latch = 1'b0; pcs = 1'b0; pc_next = 1'b0;
        reg_w = 1'b0; mem_w = 1'b0; no_write = 1'b0;
    endtask

    // Force cond_ex=1 via AL, then load the flags.
    task automatic set_flags(input logic [3:0] f);
        cond = 4'b1110; cond_latch = 1'b1; flag_w = 2'b00;
        step();
        cond_latch = 1'b0; alu_flags_i = f; flag_w = 2'b11;
        step();
        flag_w = 2'b00;
    endtask

    typedef struct {
        logic [3:0] flags;
        logic [3:0] cnd;
        logic       exp_pass;
    } vec_t;

    vec_t vecs[24];

    initial begin
        vecs[0]  = '{4'b0110, 4'b0000, 1'b1};
        vecs[1]  = '{4'b0110, 4'b0001, 1'b0};
        vecs[2]  = '{4'b0110, 4'b1000, 1'b0};
        vecs[3]  = '{4'b0110, 4'b1001, 1'b1};
        vecs[4]  = '{4'b1001, 4'b1010, 1'b1};
        vecs[5]  = '{4'b1001, 4'b1011, 1'b0};
        vecs[6]  = '{4'b1001, 4'b1100, 1'b1};
        vecs[7]  = '{4'b1001, 4'b1101, 1'b0};
        vecs[8]  = '{4'b1001, 4'b0100, 1'b1};
        vecs[9]  = '{4'b1001, 4'b0101, 1'b0};
        vecs[10] = '{4'b1001, 4'b0110, 1'b1};
        vecs[11] = '{4'b1001, 4'b0111, 1'b0};
        vecs[12] = '{4'b1001, 4'b0010, 1'b0};
        vecs[13] = '{4'b1001, 4'b0011, 1'b1};
        vecs[14] = '{4'b1100, 4'b1101, 1'b1};
        vecs[15] = '{4'b1100, 4'b1100, 1'b0};
        vecs[16] = '{4'b1100, 4'b1010, 1'b0};
        vecs[17] = '{4'b1100, 4'b1011, 1'b1};
        vecs[18] = '{4'b0010, 4'b1000, 1'b1};
        vecs[19] = '{4'b0010, 4'b1001, 1'b0};
        vecs[20] = '{4'b0000, 4'b1110, 1'b1};
        vecs[21] = '{4'b0000, 4'b1111, 1'b0};
        vecs[22] = '{4'b0000, 4'b0001, 1'b1};
        vecs[23] = '{4'b0100, 4'b0001, 1'b0};

        run = 1'b0;
        reset_n = 1'b1;
        idle_inputs();
        model_reset();

        // Reset with the clock stopped
        #1 reset_n = 1'b0;
        #2;
        check("rst_flags", 32'(flags_q), 32'h0);
        check("rst_cond_ex", 32'(cond_ex), 32'h1);
        check("rst_alu_out", alu_out_q, 32'h0);
        check("rst_undef", 32'(undef_cond), 32'h0);
        reg_w = 1'b1;
        #1;
        check("rst_reg_write", 32'(reg_write), 32'h1);
        reg_w = 1'b0;
        #2 reset_n = 1'b1;
        run = 1'b1;
        step();

        // SUBS then EQ / NE
        alu_flags_i = 4'b0110; flag_w = 2'b11;
        step();
        flag_w = 2'b00;
        check("subs_flags", 32'(flags_q), 32'h6);
        cond = 4'b0000; cond_latch = 1'b1;
        step();
        check("eq_pass", 32'(cond_ex), 32'h1);
        cond = 4'b0001;
        step();
        cond_latch = 1'b0;
        check("ne_fail", 32'(cond_ex), 32'h0);
        reg_w = 1'b1; mem_w = 1'b1; pc_next = 1'b1; #1;
        check("ne_reg_write", 32'(reg_write), 32'h0);
        check("ne_mem_write", 32'(mem_write), 32'h0);
        check("ne_pc_next", 32'(pc_write), 32'h1);
        reg_w = 1'b0; mem_w = 1'b0; pc_next = 1'b0;

        // Partial update of N,Z only
        set_flags(4'b0000);
        alu_flags_i = 4'b1111; flag_w = 2'b10;
        step();
        check("partial_nz", 32'(flags_q), 32'hC);
        alu_flags_i = 4'b0000; flag_w = 2'b01;
        step();
        check("partial_cv", 32'(flags_q), 32'hC);
        flag_w = 2'b00;

        // Condition table
        for (int i = 0; i < 24; i++) begin
            set_flags(vecs[i].flags);
            cond = vecs[i].cnd; cond_latch = 1'b1;
            step();
            cond_latch = 1'b0;
            check($sformatf("cond_vec%0d", i), 32'(cond_ex), 32'(vecs[i].exp_pass));
        end

        // Simultaneous latch and flag write: old cond_ex gates the flags
        set_flags(4'b0000);
        cond = 4'b0000; cond_latch = 1'b1;
        step();
        check("sim_pre_cond_ex", 32'(cond_ex), 32'h0);
        alu_flags_i = 4'b1111; flag_w = 2'b11; cond = 4'b1110; cond_latch = 1'b1;
        step();
        flag_w = 2'b00; cond_latch = 1'b0;
        check("sim_flags_hold", 32'(flags_q), 32'h0);
        check("sim_cond_ex", 32'(cond_ex), 32'h1);

        // Undefined condition, then asynchronous reset mid-cycle
        cond = 4'b1111; cond_latch = 1'b1;
        step();
        cond_latch = 1'b0; cond = 4'b1110;
        check("nv_cond_ex", 32'(cond_ex), 32'h0);
        check("nv_undef", 32'(undef_cond), 32'h1);
        pcs = 1'b1; pc_next = 1'b0; #1;
        check("nv_pc_write", 32'(pc_write), 32'h0);
        step();
        check("nv_undef_hold", 32'(undef_cond), 32'h1);
        pcs = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("arst_undef", 32'(undef_cond), 32'h0);
        check("arst_cond_ex", 32'(cond_ex), 32'h1);
        check("arst_flags", 32'(flags_q), 32'h0);
        reset_n = 1'b1;
        step();

        // Random stimulus against the model
        for (int k = 0; k < 400; k++) begin
            alu_result_i = $urandom;
            alu_flags_i  = 4'($urandom);
            cond         = 4'($urandom);
            flag_w       = 2'($urandom);
            cond_latch   = ($urandom_range(0, 2) == 0);
            pcs          = 1'($urandom);
            pc_next      = 1'($urandom);
            reg_w        = 1'($urandom);
            mem_w        = 1'($urandom);
            no_write     = 1'($urandom);
            #1;
            check("rnd_pc_write", 32'(pc_write), 32'(pc_next || (pcs && m_cond_ex)));
            check("rnd_reg_write", 32'(reg_write), 32'(reg_w && m_cond_ex && !no_write));
            check("rnd_mem_write", 32'(mem_write), 32'(mem_w && m_cond_ex));
            step();
            check("rnd_flags", 32'(flags_q), 32'(m_flags));
            check("rnd_cond_ex", 32'(cond_ex), 32'(m_cond_ex));
            check("rnd_undef", 32'(undef_cond), 32'(m_undef));
            check("rnd_alu_out", alu_out_q, m_alu);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
